// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and saturating stall/flush performance counters.
module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             m_valid, s_valid;
    logic [WIDTH-1:0] m_data, s_data;
    logic             m_valid_nxt, s_valid_nxt;
    logic [WIDTH-1:0] m_data_nxt, s_data_nxt;
    logic             push, pop;
    logic             stall_evt, flush_evt;

    // Skid mode: in_ready comes straight from the skid valid flop, breaking the
    // combinational ready path from downstream.
    assign in_ready  = (SKID != 0) ? ~s_valid : (~m_valid | out_ready);
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occ       = {1'b0, m_valid} + {1'b0, s_valid};

    assign push      = in_valid & in_ready;
    assign pop       = m_valid & out_ready;
    assign stall_evt = m_valid & ~out_ready;
    assign flush_evt = flush & (m_valid | s_valid);

    always_comb begin
        m_valid_nxt = m_valid;
        m_data_nxt  = m_data;
        s_valid_nxt = s_valid;
        s_data_nxt  = s_data;
        if (flush) begin
            m_valid_nxt = 1'b0;
            m_data_nxt  = '0;
            s_valid_nxt = 1'b0;
            s_data_nxt  = '0;
        end else if (SKID != 0) begin
            if (pop) begin
                if (s_valid) begin
                    m_data_nxt  = s_data;
                    s_valid_nxt = 1'b0;
                end else if (push) begin
                    m_data_nxt = in_data;
                end else begin
                    m_valid_nxt = 1'b0;
                end
            end else if (push) begin
                if (!m_valid) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = in_data;
                end else begin
                    s_valid_nxt = 1'b1;
                    s_data_nxt  = in_data;
                end
            end
        end else begin
            s_valid_nxt = 1'b0;
            s_data_nxt  = '0;
            if (push) begin
                m_valid_nxt = 1'b1;
                m_data_nxt  = in_data;
            end else if (pop) begin
                m_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_nxt;
            m_data  <= m_data_nxt;
            s_valid <= s_valid_nxt;
            s_data  <= s_data_nxt;
        end
    end

    // Counters saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; next generation of the fixed IF/ID latch.
- Carries an arbitrary WIDTH payload, for example {IR, PC} = 64 bits, between two pipeline stages.
- Uses a valid/ready handshake in place of bare EN/CLR, with an optional 2-entry skid buffer so stalls do not cost throughput.
- Adds a synchronous flush for branch/exception squash and saturating stall/flush counters for performance debug.

Parameters:
- WIDTH, 64, payload width in bits.
- SKID, 1, selects the mode. 1 = 2-entry skid buffer with registered in_ready. 0 = single register with combinational in_ready.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  Pipeline clock. All state changes occur on its rising edge.
- rst  input  1  Reset, asynchronous, active-high. Clears all state.
- in_valid  input  1  Upstream offers in_data.
- in_ready  output  1  Stage can accept in_data this cycle.
- in_data  input  WIDTH  Upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  Downstream accepts out_data this cycle.
- out_data  output  WIDTH  Payload to downstream.
- flush  input  1  Synchronous squash of all held entries.
- occ  output  2  Number of valid entries held, 0 to 2 (0 to 1 when SKID=0).
- stall_cnt  output  CNT_W  Cycles with out_valid=1 and out_ready=0, saturating.
- flush_cnt  output  CNT_W  Flushes that discarded at least one valid entry, saturating.

Behaviour:
- Storage: main entry M (m_valid, m_data); skid entry S (s_valid, s_data), present only when SKID=1.
- Outputs: out_valid = m_valid and out_data = m_data at all times; both come directly from registers.
- Events: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (asynchronous, rst=1):
  - m_valid, s_valid, m_data, s_data, stall_cnt, flush_cnt all go to 0.
  - Resulting outputs: out_valid=0, out_data=0, occ=0, and in_ready=1 in both modes.
  - rst asserted mid-transfer drops all entries immediately; there is no partial update.
- Priority order: rst > flush > normal handshake.
- Flush (flush=1 at a clock edge):
  - m_valid, s_valid, m_data and s_data all go to 0.
  - Any push in the same cycle is discarded; in_ready keeps its normal value.
  - A pop in the same cycle still completes from the downstream side, since data was presented.
  - flush_cnt increments if m_valid | s_valid was 1 before the edge.
- SKID=1, normal operation:
  - in_ready = ~s_valid, which is registered.
  - Pop with s_valid=1: M <= S, S becomes empty. No push is possible in this case.
  - Pop with s_valid=0: if push, M <= in_data; otherwise M becomes empty.
  - No pop, m_valid=0, push: M <= in_data.
  - No pop, m_valid=1, push: S <= in_data, and in_ready drops next cycle.
  - Latency is 1 cycle from push to out_valid when M was empty or popped.
  - Sustained throughput is 1 transfer per cycle.
  - One cycle of out_ready=0 absorbs exactly one extra beat in S without bubbles.
- SKID=0, normal operation:
  - in_ready = ~m_valid | out_ready, which is combinational.
  - On push: M <= in_data.
  - On pop with no push: M becomes empty.
- Entry state: data registers hold their value when not written; the valid bits are authoritative.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush or rst.
- occ = m_valid + s_valid.
- Counters:
  - Increment at most once per cycle.
  - Saturate at 2^CNT_W − 1; they do not wrap.
  - Only rst clears them; flush does not.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle with a full stage (occ=2) -> out_valid=0, occ=0, in_ready=1 and counters 0 immediately, before the next clock edge.
- Streaming, SKID=1: in_valid=1 for 8 cycles with data 0x1..0x8 and out_ready=1 constantly -> out_data 0x1..0x8 on 8 consecutive cycles starting 1 cycle later; stall_cnt=0.
- Backpressure/skid: stream 0xA,0xB,0xC with out_ready=0 for 2 cycles -> occ reaches 2 and in_ready=0 -> release out_ready -> 0xA,0xB,0xC delivered in order with no loss; stall_cnt=2.
- Flush: occ=2, flush=1 with a simultaneous push of 0xFF -> next cycle out_valid=0, occ=0, and 0xFF never appears; flush_cnt=1. A flush while empty leaves flush_cnt unchanged.
- SKID=0: out_ready=0 with M full -> in_ready=0 in the same cycle. Assert out_ready=1 with a push of 0x5 -> 0x5 appears next cycle with no bubble.
- Saturation: CNT_W=4, hold a valid beat with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
